sram_fifo_ctrl: RTL
===================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning word width on all data paths.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning SRAM address width; DEPTH = 2**ADDR_WIDTH = 256 words.
REQ-003 SHALL have parameter NUM_WMASKS, default 4, meaning byte-write mask width (DATA_WIDTH/8).
REQ-004 SHALL have ports, one per line:
  clk  input  1  sole clock; all state updates on rising edge; the 1RW1R macro's clk0 and clk1 are tied to it
  rst  input  1  asynchronous active-high reset
  in_valid  input  1  push request
  in_ready  output  1  push accepted when in_valid&in_ready
  in_data  input  DATA_WIDTH  push word
  out_valid  output  1  pop word available
  out_ready  input  1  pop accepted when out_valid&out_ready
  out_data  output  DATA_WIDTH  head word
  level  output  ADDR_WIDTH+1  total words held (0..DEPTH+2)
  csb0  output  1  macro port0 active-low select
  web0  output  1  macro port0 active-low write enable
  wmask0  output  NUM_WMASKS  macro port0 write mask
  addr0  output  ADDR_WIDTH  macro port0 address
  din0  output  DATA_WIDTH  macro port0 write data
  csb1  output  1  macro port1 active-low select
  addr1  output  ADDR_WIDTH  macro port1 address
  dout1  input  DATA_WIDTH  macro port1 read data, valid in the cycle after the issuing edge

Function
REQ-005 SHALL implement a first-in first-out queue: SRAM storage (port0 write-only, port1 read-only) followed by a 2-entry output buffer (obuf).
REQ-006 SHALL keep state: wr_ptr, rd_ptr (ADDR_WIDTH bits, wrap DEPTH-1->0), sram_cnt (0..DEPTH), inflight (0/1), obuf_cnt (0..2).
REQ-007 SHALL drive in_ready = !rst & (sram_cnt < DEPTH); push = in_valid & in_ready.
REQ-008 SHALL drive, combinationally: csb0 = web0 = !push; wmask0 = all ones; addr0 = wr_ptr; din0 = in_data.
REQ-009 SHALL compute pop = out_valid & out_ready; rd_issue = (sram_cnt > 0) & (obuf_cnt + inflight - pop < 2).
REQ-010 SHALL drive csb1 = !rd_issue and addr1 = rd_ptr, combinationally.
REQ-011 SHALL, on an edge with push, increment wr_ptr; with rd_issue, increment rd_ptr; sram_cnt += push - rd_issue (both in one cycle leaves sram_cnt unchanged).
REQ-012 SHALL set inflight <= rd_issue each edge; when inflight is 1, capture dout1 into obuf tail on that edge.
REQ-013 SHALL update obuf_cnt += inflight - pop; out_valid = (obuf_cnt > 0); out_data = obuf head; pop advances head.
REQ-014 SHALL hold out_data stable while out_valid & !out_ready.
REQ-015 SHALL drive level = sram_cnt + inflight + obuf_cnt.
REQ-016 SHALL, with out_ready held high, sustain one push and one pop per cycle indefinitely.
REQ-017 SHALL give latency: word pushed at edge N into an empty FIFO is read-issued in cycle N+1 and presents out_valid=1 after edge N+2.
REQ-018 SHALL never issue a port1 read of an address being written in the same cycle (guaranteed since rd_issue requires the word already counted in sram_cnt).
REQ-019 SHALL ignore in_valid when full (in_ready=0) and out_ready when empty (out_valid=0); no state change results.
REQ-020 SHALL preserve order across wr_ptr/rd_ptr wrap-around at DEPTH.

Reset
REQ-021 SHALL, on rst assertion at any time including mid-transfer, asynchronously clear wr_ptr, rd_ptr, sram_cnt, inflight, obuf_cnt; all queued data is discarded.
REQ-022 SHALL present during and after reset: in_ready=0 during reset, 1 after; out_valid=0; level=0; csb0=1; web0=1; csb1=1; out_data=0.

Verification
REQ-023 Single word: push 0xDEADBEEF at edge N, out_ready=1 -> out_valid rises after edge N+2, out_data=0xDEADBEEF, level returns to 0 after pop.
REQ-024 Fill: out_ready=0, push 1..258 -> level=258, in_ready=0 at sram_cnt=256, 259th word rejected; drain yields 1..258 in order.
REQ-025 Streaming: in_valid=out_ready=1 for 1000 cycles, incrementing data -> one pop per cycle after fill latency, no gaps, no reordering across 3 pointer wraps.
REQ-026 Backpressure: random out_ready toggling -> out_data constant while stalled, no loss/duplication, csb1 never low while obuf_cnt+inflight-pop would exceed 2.
REQ-027 Reset mid-operation: assert rst with level=100 and read inflight -> outputs per REQ-022 immediately; subsequent push 0x1 emerges first.
REQ-028 Collision check: assertion that addr1 != addr0 whenever csb0=0 and csb1=0 holds over all tests.

Source files
------------

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over a 1RW1R SRAM macro: port0 writes pushed words, port1 prefetches
// into a 2-entry output buffer so one push and one pop can proceed every cycle.
module sram_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NUM_WMASKS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1
);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   sram_cnt_q, sram_cnt_d;
  logic                  inflight_q;
  logic [1:0]            obuf_cnt_q, obuf_cnt_d;
  logic                  obuf_head_q, obuf_head_d;
  logic [DATA_WIDTH-1:0] obuf_q [2];
  logic                  obuf_wr_idx;

  logic       push, pop, rd_issue;
  logic [2:0] obuf_occ;

  // sram_cnt never exceeds DEPTH, so its MSB alone flags "full".
  assign in_ready  = !rst && !sram_cnt_q[ADDR_WIDTH];
  assign push      = in_valid && in_ready;
  assign out_valid = (obuf_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Occupancy of obuf once this cycle's pop and pending read data are accounted for.
  assign obuf_occ = {1'b0, obuf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue = (sram_cnt_q != '0) && (obuf_occ < 3'd2);

  assign csb0   = !push;
  assign web0   = !push;
  assign wmask0 = '1;
  assign addr0  = wr_ptr_q;
  assign din0   = in_data;
  assign csb1   = !rd_issue;
  assign addr1  = rd_ptr_q;

  assign out_data = out_valid ? obuf_q[obuf_head_q] : '0;
  assign level    = sram_cnt_q + {{ADDR_WIDTH{1'b0}}, inflight_q}
                  + {{(ADDR_WIDTH-1){1'b0}}, obuf_cnt_q};

  // When read data lands, obuf holds at most one word, so the tail slot is always free.
  assign obuf_wr_idx = obuf_head_q ^ obuf_cnt_q[0];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    sram_cnt_d  = sram_cnt_q;
    obuf_cnt_d  = obuf_cnt_q;
    obuf_head_d = obuf_head_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    unique case ({push, rd_issue})
      2'b10:   sram_cnt_d = sram_cnt_q + 1'b1;
      2'b01:   sram_cnt_d = sram_cnt_q - 1'b1;
      default: sram_cnt_d = sram_cnt_q;
    endcase
    unique case ({inflight_q, pop})
      2'b10:   obuf_cnt_d = obuf_cnt_q + 1'b1;
      2'b01:   obuf_cnt_d = obuf_cnt_q - 1'b1;
      default: obuf_cnt_d = obuf_cnt_q;
    endcase
    if (pop) begin
      obuf_head_d = !obuf_head_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sram_cnt_q  <= '0;
      inflight_q  <= 1'b0;
      obuf_cnt_q  <= '0;
      obuf_head_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      sram_cnt_q  <= sram_cnt_d;
      inflight_q  <= rd_issue;
      obuf_cnt_q  <= obuf_cnt_d;
      obuf_head_q <= obuf_head_d;
    end
  end

  // Data storage needs no reset; out_data is masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (inflight_q) begin
      obuf_q[obuf_wr_idx] <= dout1;
    end
  end

endmodule
